// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one 8:1 select datapath between 8 requesters.
// The winning word is registered and presented on a single valid/ready channel.
module rr_mux8_arbiter #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] in_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      sel,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [2:0]      last;
    logic [N-1:0]    cand;
    logic [2:0]      ptr;
    logic [2:0]      winner;
    logic [DW-1:0]   winner_word;

    // Search ptr+1, ptr+2, ... wrapping mod 8; ptr itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [N-1:0] c, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = p + 3'(i);
            if (!found && c[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // The granted requester is masked during its ack cycle so a stale level cannot win twice.
    always_comb begin
        cand        = (state == IDLE) ? req : (req & ~gnt);
        ptr         = (state == IDLE) ? last : sel;
        winner      = rr_pick(cand, ptr);
        winner_word = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == 3'(i)) begin
                winner_word = in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 3'd0;
            gnt       <= '0;
            last      <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel       <= winner;
                        gnt       <= N'(1) << winner;
                        out_data  <= winner_word;
                        out_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (out_ready) begin
                        last <= sel;
                        if (|cand) begin
                            sel      <= winner;
                            gnt      <= N'(1) << winner;
                            out_data <= winner_word;
                        end else begin
                            out_valid <= 1'b0;
                            gnt       <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack  = gnt & {N{out_valid & out_ready}};
    assign busy = out_valid;

endmodule
